// File: rtl/layout_pkg.sv
// Shared layout types for the output deskew block: default sizes,
// the dimension type and the deskew FSM state encoding.
package layout_pkg;

  localparam int BITS_DEFAULT = 8;
  localparam int DIM_DEFAULT  = 32;

  typedef logic [$clog2(DIM_DEFAULT):0] dim_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } deskew_state_e;

endpackage

// File: rtl/output_deskew_if.sv
// Job control, skewed wavefront input and aligned row output of the
// deskew block, bundled with producer-side and block-side modports.
interface output_deskew_if
  import layout_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT,
  parameter int DIM  = DIM_DEFAULT
);

  localparam int DW = $clog2(DIM) + 1;

  logic                      start;
  logic [DW-1:0]             m;
  logic [DW-1:0]             n;
  logic                      in_valid;
  logic [DIM-1:0][BITS-1:0]  in_data;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIM-1:0][BITS-1:0]  out_data;
  logic                      out_last;
  logic                      busy;

  modport slave (
    input  start, m, n, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output start, m, n, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/output_deskew.sv
// Collects diagonally skewed wavefronts into an m x n buffer and replays it
// row by row. Define DESKEW_RELU_EN to clamp negative output elements to 0.
module output_deskew
  import layout_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT,
  parameter int DIM  = DIM_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output_deskew_if.slave  io
);

  localparam int DW = $clog2(DIM) + 1;
  localparam int RW = $clog2(DIM);
  localparam logic [DW-1:0] DIM_V = DW'(DIM);

  deskew_state_e            state_q, state_d;
  logic [DW-1:0]            t_q;
  logic [RW-1:0]            row_q;
  logic [DW-1:0]            m_q, n_q;
  logic [BITS-1:0]          buf_q [DIM][DIM];
  logic [DIM-1:0][BITS-1:0] row_data;

  logic go, acc, out_hs, last_step, last_row;

`ifdef DESKEW_RELU_EN
  function automatic logic [BITS-1:0] relu_clip(input logic signed [BITS-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction
`else
  function automatic logic [BITS-1:0] relu_clip(input logic signed [BITS-1:0] x);
    return x;
  endfunction
`endif

  assign go = io.start && (io.m != '0) && (io.m <= DIM_V)
                       && (io.n != '0) && (io.n <= DIM_V);
  assign acc       = io.in_valid && (state_q == COLLECT);
  assign out_hs    = io.out_ready && (state_q == DRAIN);
  // m+n may exceed the counter width; modular subtraction still lands on m+n-2
  assign last_step = (t_q == (m_q + n_q - DW'(2)));
  assign last_row  = (row_q == RW'(m_q - DW'(1)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go)                 state_d = COLLECT;
      COLLECT: if (acc && last_step)   state_d = DRAIN;
      DRAIN:   if (out_hs && last_row) state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && go) begin
        t_q   <= '0;
        row_q <= '0;
      end else begin
        if (acc)    t_q   <= t_q + 1'b1;
        if (out_hs) row_q <= row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && go) begin
      m_q <= io.m;
      n_q <= io.n;
    end
  end

  // Lane r at step t carries column t-r of row r: write where r+c == t
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          if ((t_q == DW'(r + c)) && (DW'(r) < m_q) && (DW'(c) < n_q))
            buf_q[r][c] <= io.in_data[r];
        end
      end
    end
  end

  always_comb begin
    row_data = '0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < DIM; c++) begin
        if (DW'(c) < n_q) row_data[c] = relu_clip(buf_q[row_q][c]);
      end
    end
  end

  assign io.out_data  = row_data;
  assign io.out_valid = (state_q == DRAIN);
  assign io.out_last  = (state_q == DRAIN) && last_row;
  assign io.in_ready  = (state_q == COLLECT);
  assign io.busy      = (state_q != IDLE);

endmodule

// File: doc/output_deskew.md
OUTPUT_DESKEW -- requirements
Module: output_deskew

Interface
REQ-001 SHALL have parameter BITS, default 8, meaning bit width of one output element.
REQ-002 SHALL have parameter DIM, default 32, meaning maximum feature-map dimension and lane count.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a job.
REQ-006 SHALL have ports m, n  input  $clog2(DIM)+1 each  rows and columns of the job; sampled on start.
REQ-007 SHALL have port in_valid  input  1  skewed wavefront present.
REQ-008 SHALL have port in_data  input  [DIM][BITS]  wavefront; lane r carries element of row r.
REQ-009 SHALL have port in_ready  output  1  block accepts a wavefront.
REQ-010 SHALL have port out_valid  output  1  aligned row present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the row.
REQ-012 SHALL have port out_data  output  [DIM][BITS]  aligned row; column c at index c.
REQ-013 SHALL have port out_last  output  1  marks row m-1.
REQ-014 SHALL have port busy  output  1  job in progress (not IDLE).

Function
REQ-015 SHALL implement states IDLE, COLLECT, DRAIN.
REQ-016 IDLE->COLLECT on start with 1<=m<=DIM and 1<=n<=DIM; latch m, n; clear step counter t and row counter.
REQ-017 start with m or n equal to 0 or greater than DIM SHALL be ignored (stay IDLE); start outside IDLE SHALL be ignored.
REQ-018 in_ready SHALL be 1 exactly in COLLECT; a wavefront is accepted on in_valid&&in_ready.
REQ-019 On accept at step t, for each lane r<m with 0<=t-r<n, SHALL write in_data[r] to buffer[r][t-r]; other lanes discarded.
REQ-020 t SHALL advance only on accept; gaps in in_valid SHALL not change state.
REQ-021 Accept at t=m+n-2 SHALL move to DRAIN; out_valid high the next cycle.
REQ-022 In DRAIN, out_valid=1, out_data = buffer row at row counter, columns c>=n forced to 0.
REQ-023 Row counter SHALL advance on out_valid&&out_ready; out_last=1 while row counter = m-1.
REQ-024 Handshake on the out_last row SHALL return to IDLE; start in that same cycle is ignored.
REQ-025 out_data SHALL be all zeros whenever out_valid=0; row data SHALL hold stable while out_valid&&!out_ready.

Reset
REQ-026 rst SHALL force IDLE, t=0, row counter=0, out_valid=0, out_last=0, in_ready=0, busy=0, out_data=0, including mid-COLLECT or mid-DRAIN.
REQ-027 Buffer contents need not be cleared; every read location is rewritten within a job.

Configuration
REQ-028 Macro DESKEW_RELU_EN defined: each out_data element SHALL be treated as signed BITS and output 0 when negative.
REQ-029 DESKEW_RELU_EN undefined: out_data SHALL pass buffer values unchanged; no ReLU logic synthesized.

Structure
REQ-030 Package layout_pkg SHALL hold BITS, DIM defaults, dim_t typedef ($clog2(DIM)+1 bits) and the deskew state enum.
REQ-031 No sub-module is required; write decode, FSM and buffer SHALL reside in output_deskew.

Verification
REQ-032 m=n=32, element[r][c]=r*32+c mod 256 fed as 63 skewed wavefronts with no gaps -> 32 rows out, row r col c = r*32+c mod 256, out_last on row 31.
REQ-033 m=n=14, random data, in_valid gaps every third cycle -> 27 accepts then 14 correct rows; columns 14..31 zero.
REQ-034 m=3, n=7, out_ready low 2 cycles per row -> out_data stable while stalled; 3 rows, out_last on row 2; busy falls after final handshake.
REQ-035 m=n=5, rst asserted after 4 accepts -> next cycle IDLE, all outputs 0; fresh 5x5 job then completes correctly.
REQ-036 start with m=0, n=5 and start during COLLECT -> both ignored; busy unchanged.
REQ-037 DESKEW_RELU_EN defined, m=n=5, element 8'h80 at [2][3], 8'h7F at [0][0] -> out [2][3]=0, [0][0]=8'h7F; undefined -> 8'h80 passes.
